// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encodings and helpers for the alarm controller
package alarm_pkg;

  localparam int IDLE_B = 0;
  localparam int ARMED_B = 1;
  localparam int RING_B = 2;
  localparam int SNZ_B = 3;
  localparam int DONE_B = 4;

  localparam logic [4:0] IDLE_OH  = 5'b00001;
  localparam logic [4:0] ARMED_OH = 5'b00010;
  localparam logic [4:0] RING_OH  = 5'b00100;
  localparam logic [4:0] SNZ_OH   = 5'b01000;
  localparam logic [4:0] DONE_OH  = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE  = IDLE_OH,
    S_ARMED = ARMED_OH,
    S_RING  = RING_OH,
    S_SNZ   = SNZ_OH,
    S_DONE  = DONE_OH
  } alarm_state_e;

  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'b0) && ((v & (v - 5'd1)) == 5'b0);
  endfunction

endpackage

// File: rtl/alarm_tick_cnt.sv
// rtl/alarm_tick_cnt.sv - loadable tick down-counter shared by ring timeout and snooze
module alarm_tick_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Decrement stops at 1 so the counter can never wrap through zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alarm_fsm_ctrl.sv
// rtl/alarm_fsm_ctrl.sv - one-hot alarm clock control FSM driving buzzer and snooze indicator
module alarm_fsm_ctrl
  import alarm_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             alarm_en,
  input  logic             time_match,
  input  logic             snooze_btn,
  input  logic             off_btn,
  output logic [4:0]       state,
  output logic             buzz,
  output logic             snooze_active,
  output logic [CNT_W-1:0] cnt,
  output logic             illegal_state
);

  logic [4:0]       state_q;
  alarm_state_e     state_d;
  logic             illegal_q;
  logic             illegal_d;
  logic             cnt_load;
  logic             cnt_clr;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_is_one;

  // Buttons are checked ahead of tick so a same-cycle tick is dropped.
  always_comb begin
    state_d      = alarm_state_e'(state_q);
    cnt_load     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = CNT_W'(RING_TICKS);
    illegal_d    = !is_onehot5(state_q);
    if (illegal_d) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (alarm_en) begin
            state_d = S_ARMED;
            cnt_clr = 1'b1;
          end
        end
        S_ARMED: begin
          if (!alarm_en) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end else if (time_match) begin
            state_d  = S_RING;
            cnt_load = 1'b1;
          end
        end
        S_RING: begin
          if (!alarm_en) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end else if (off_btn) begin
            state_d = S_DONE;
            cnt_clr = 1'b1;
          end else if (snooze_btn) begin
            state_d      = S_SNZ;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(SNOOZE_TICKS);
          end else if (tick) begin
            if (cnt_is_one) begin
              state_d = S_DONE;
              cnt_clr = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        S_SNZ: begin
          if (!alarm_en) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end else if (off_btn) begin
            state_d = S_DONE;
            cnt_clr = 1'b1;
          end else if (tick) begin
            if (cnt_is_one) begin
              state_d  = S_RING;
              cnt_load = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        S_DONE: begin
          // Stay here until the match window closes so one match rings once.
          if (!alarm_en) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end else if (!time_match) begin
            state_d = S_ARMED;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_OH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  alarm_tick_cnt #(
    .CNT_W(CNT_W)
  ) u_tick_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .clr     (cnt_clr),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .is_one  (cnt_is_one)
  );

  assign state         = state_q;
  assign buzz          = state_q[RING_B];
  assign snooze_active = state_q[SNZ_B];
  assign illegal_state = illegal_q;

endmodule

// File: tb/tb_alarm_fsm_ctrl.sv
// tb/tb_alarm_fsm_ctrl.sv - directed and randomized checks of alarm_fsm_ctrl against a reference model
module tb_alarm_fsm_ctrl;

  localparam int CNT_W = 8;
  localparam int RT    = 3;
  localparam int ST    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             alarm_en = 1'b0;
  logic             time_match = 1'b0;
  logic             snooze_btn = 1'b0;
  logic             off_btn = 1'b0;
  logic [4:0]       state;
  logic             buzz;
  logic             snooze_active;
  logic [CNT_W-1:0] cnt;
  logic             illegal_state;

  int passed = 0;
  int total  = 0;

  // Reference model: phase 0..4 = idle, armed, ringing, snooze, done; rem = ticks left.
  int m_ph  = 0;
  int m_rem = 0;

  always #5 clk = ~clk;

  alarm_fsm_ctrl #(
    .CNT_W(CNT_W),
    .RING_TICKS(RT),
    .SNOOZE_TICKS(ST)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .alarm_en(alarm_en),
    .time_match(time_match),
    .snooze_btn(snooze_btn),
    .off_btn(off_btn),
    .state(state),
    .buzz(buzz),
    .snooze_active(snooze_active),
    .cnt(cnt),
    .illegal_state(illegal_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    case (m_ph)
      0: if (alarm_en) m_ph = 1;
      1: begin
        if (!alarm_en) m_ph = 0;
        else if (time_match) begin m_ph = 2; m_rem = RT; end
      end
      2: begin
        if (!alarm_en) begin m_ph = 0; m_rem = 0; end
        else if (off_btn) begin m_ph = 4; m_rem = 0; end
        else if (snooze_btn) begin m_ph = 3; m_rem = ST; end
        else if (tick) begin
          if (m_rem == 1) begin m_ph = 4; m_rem = 0; end
          else m_rem = m_rem - 1;
        end
      end
      3: begin
        if (!alarm_en) begin m_ph = 0; m_rem = 0; end
        else if (off_btn) begin m_ph = 4; m_rem = 0; end
        else if (tick) begin
          if (m_rem == 1) begin m_ph = 2; m_rem = RT; end
          else m_rem = m_rem - 1;
        end
      end
      default: begin
        if (!alarm_en) m_ph = 0;
        else if (!time_match) m_ph = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag, input logic exp_ill);
    chk({tag, ".state"}, 32'(state), 32'(1) << m_ph);
    chk({tag, ".buzz"}, 32'(buzz), 32'(m_ph == 2));
    chk({tag, ".snooze"}, 32'(snooze_active), 32'(m_ph == 3));
    chk({tag, ".cnt"}, 32'(cnt), 32'(m_rem));
    chk({tag, ".illegal"}, 32'(illegal_state), 32'(exp_ill));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag, 1'b0);
  endtask

  task automatic pulse_tick(input string tag);
    tick = 1'b1;
    cycle(tag);
    tick = 1'b0;
  endtask

  initial begin
    // Reset and arm
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    rst = 1'b0;
    alarm_en = 1'b1;
    cycle("arm");

    // Ring timeout after RT ticks, with idle cycles in between
    time_match = 1'b1;
    cycle("ring_start");
    for (int i = 0; i < RT; i++) begin
      cycle("ring_gap");
      pulse_tick("ring_tick");
    end
    chk("timeout_done", 32'(state), 32'h10);
    cycle("done_hold");
    time_match = 1'b0;
    cycle("done_to_armed");

    // Snooze cycle back into ringing
    time_match = 1'b1;
    cycle("ring2");
    snooze_btn = 1'b1;
    cycle("snooze_enter");
    snooze_btn = 1'b0;
    chk("snooze_cnt", 32'(cnt), 32'(ST));
    for (int i = 0; i < ST; i++) pulse_tick("snooze_tick");
    chk("rering_cnt", 32'(cnt), 32'(RT));

    // All three pulses together while ringing
    snooze_btn = 1'b1; off_btn = 1'b1; tick = 1'b1;
    cycle("simul");
    snooze_btn = 1'b0; off_btn = 1'b0; tick = 1'b0;
    chk("simul_done", 32'(state), 32'h10);

    // Disable wins over off_btn
    time_match = 1'b0;
    cycle("rearm");
    time_match = 1'b1;
    cycle("ring3");
    alarm_en = 1'b0; off_btn = 1'b1;
    cycle("disable_off");
    off_btn = 1'b0;
    chk("disable_idle", 32'(state), 32'h01);

    // Illegal state recovery
    alarm_en = 1'b1; time_match = 1'b0;
    cycle("arm_again");
    force u_dut.state_q = 5'b00110;
    #7;
    release u_dut.state_q;
    @(posedge clk);
    m_ph = 0; m_rem = 0;
    #1;
    check_all("illegal_rec", 1'b1);
    cycle("illegal_clear");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      alarm_en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 4) == 0) time_match = ~time_match;
      tick       = ($urandom_range(0, 9) < 4);
      snooze_btn = ($urandom_range(0, 9) == 0);
      off_btn    = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    tick = 1'b0; snooze_btn = 1'b0; off_btn = 1'b0;

    // Async reset while ringing
    alarm_en = 1'b1;
    for (int i = 0; i < 20 && m_ph != 2; i++) begin
      time_match = (i > 0);
      cycle("seek_ring");
    end
    chk("ring_before_rst", 32'(buzz), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    m_ph = 0; m_rem = 0;
    check_all("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    alarm_en = 1'b0;
    cycle("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
